// File: rtl/storage_arbiter.sv
// ---------------------------------------------------------------------------
// storage_arbiter
//
// Shares the single memory port of storage_controller among N_REQ requesters
// (index 0 = instruction fetch, then scalar LSU, vector LSU). One request is
// granted at a time: the winner's command is latched, held on the controller
// port until out_valid or a timeout, and a one-cycle completion pulse carrying
// read data or an error goes back to the winner. New grants are blocked while
// the controller is in programming mode.
//
// Configuration macro:
//   STORAGE_ARB_RR_EN  defined   -> round-robin arbitration (search starts one
//                                   past the last winner)
//                      undefined -> fixed priority, lowest index wins; no
//                                   pointer register is built
//
// Parameters:
//   N_REQ    number of requesters (2..4)
//   TIMEOUT  maximum ACCESS cycles to wait for out_valid (>= 2)
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_valid/we       per-requester request strobe and write flag
//   req_addr/wdata     32-bit lane per requester (lane i = bits [32i+31:32i])
//   req_be             4-bit byte-enable lane per requester
//   req_ready          one-hot grant, combinational, only while idle
//   rsp_valid          one-hot, one-cycle completion pulse
//   rsp_rdata/rsp_err  completion data / timeout flag, valid with rsp_valid
//   prog_mode          controller programming mode, blocks new grants
//   memory_access,
//   memory_is_writing,
//   addr, d_in, mem_be command to storage_controller, zero outside ACCESS
//   d_out, out_valid   read data / completion from storage_controller
// ---------------------------------------------------------------------------
module storage_arbiter #(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_we,
    input  logic [32*N_REQ-1:0]  req_addr,
    input  logic [32*N_REQ-1:0]  req_wdata,
    input  logic [4*N_REQ-1:0]   req_be,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    input  logic                 prog_mode,
    output logic                 memory_access,
    output logic                 memory_is_writing,
    output logic [31:0]          addr,
    output logic [31:0]          d_in,
    output logic [3:0]           mem_be,
    input  logic [31:0]          d_out,
    input  logic                 out_valid
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [IDX_W-1:0] gnt_idx;
    logic             lat_we;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;
    logic [3:0]       lat_be;
    logic [CNT_W-1:0] timer;
    logic [31:0]      rsp_rdata_q;
    logic             rsp_err_q;

    logic             any_win;
    logic [IDX_W-1:0] win_idx;
    logic             grant;

    logic             sel_we;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic [3:0]       sel_be;

`ifdef STORAGE_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;
    int               dist;
    int               best_dist;

    // Round-robin pick: each pending requester's distance from the slot just
    // after the pointer is computed and the nearest one wins, which is the
    // same as scanning pointer+1, pointer+2, ... modulo N_REQ.
    always_comb begin
        any_win   = 1'b0;
        win_idx   = '0;
        dist      = 0;
        best_dist = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            dist = (i + N_REQ - 1 - int'(rr_ptr)) % N_REQ;
            if (req_valid[i] && (dist < best_dist)) begin
                best_dist = dist;
                any_win   = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end

    // Pointer remembers the last winner; reset value makes index 0 first.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= IDX_W'(N_REQ - 1);
        end else if (grant) begin
            rr_ptr <= win_idx;
        end
    end
`else
    // Fixed priority: scanning downwards leaves the lowest pending index.
    always_comb begin
        any_win = 1'b0;
        win_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any_win = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
    end
`endif

    assign grant = (state == IDLE) && !prog_mode && any_win;

    // Steer the winner's command lane so it can be latched on the grant edge.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[32*i +: 32];
                sel_wdata = req_wdata[32*i +: 32];
                sel_be    = req_be[4*i +: 4];
            end
        end
    end

    // The grant is suppressed while rst is high: the edge that would accept
    // it also resets the FSM, so a requester must not believe it was taken.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = grant && !rst && (win_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // out_valid is tested before the timeout so a completion arriving on the
    // last allowed cycle is reported as a normal response.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (out_valid || (timer == CNT_LAST)) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command latch, timeout counter and response capture. Writes complete
    // with zero read data; a timeout completes with zero data and the error.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_idx     <= '0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_be      <= '0;
            timer       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        gnt_idx   <= win_idx;
                        lat_we    <= sel_we;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        lat_be    <= sel_be;
                        timer     <= '0;
                    end
                end
                ACCESS: begin
                    timer <= timer + CNT_W'(1);
                    if (out_valid) begin
                        rsp_rdata_q <= lat_we ? 32'h0 : d_out;
                        rsp_err_q   <= 1'b0;
                    end else if (timer == CNT_LAST) begin
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Controller-side command is only driven during ACCESS and is zero
    // otherwise; the response is only visible during RESP.
    always_comb begin
        memory_access     = (state == ACCESS);
        memory_is_writing = 1'b0;
        addr              = '0;
        d_in              = '0;
        mem_be            = '0;
        rsp_rdata         = '0;
        rsp_err           = 1'b0;
        rsp_valid         = '0;
        if (state == ACCESS) begin
            memory_is_writing = lat_we;
            addr              = lat_addr;
            d_in              = lat_wdata;
            mem_be            = lat_be;
        end
        if (state == RESP) begin
            rsp_rdata = rsp_rdata_q;
            rsp_err   = rsp_err_q;
            for (int i = 0; i < N_REQ; i++) begin
                rsp_valid[i] = (gnt_idx == IDX_W'(i));
            end
        end
    end

endmodule

// File: tb/tb_storage_arbiter.sv
// ---------------------------------------------------------------------------
// tb_storage_arbiter
//
// Bench for storage_arbiter with N_REQ=3 and TIMEOUT=8. A directed vector
// table covers reset, single read, write, contention, programming mode and
// reset during an access; a hand-written sequence covers the timeout; a
// randomized phase drives random requests and controller latencies against a
// transaction-level model of the arbitration and response rules.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_storage_arbiter;

    localparam int N   = 3;
    localparam int TMO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_we;
    logic [32*N-1:0] req_addr;
    logic [32*N-1:0] req_wdata;
    logic [4*N-1:0]  req_be;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic            prog_mode;
    logic            memory_access;
    logic            memory_is_writing;
    logic [31:0]     addr;
    logic [31:0]     d_in;
    logic [3:0]      mem_be;
    logic [31:0]     d_out;
    logic            out_valid;

    int checks   = 0;
    int failures = 0;

    storage_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (TMO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_we            (req_we),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_be            (req_be),
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_rdata         (rsp_rdata),
        .rsp_err           (rsp_err),
        .prog_mode         (prog_mode),
        .memory_access     (memory_access),
        .memory_is_writing (memory_is_writing),
        .addr              (addr),
        .d_in              (d_in),
        .mem_be            (mem_be),
        .d_out             (d_out),
        .out_valid         (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [2:0]  rv;
        logic [2:0]  we;
        logic        pm;
        logic        ov;
        logic [31:0] dout;
        logic [2:0]  e_rdy;
        logic        e_acc;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [31:0] e_din;
        logic [3:0]  e_be;
        logic [2:0]  e_rsv;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    // Fixed command lanes used by the directed table.
    function automatic logic [31:0] lane_addr(input int i);
        case (i)
            0:       return 32'h0000_0400;
            1:       return 32'h0000_0010;
            default: return 32'h0000_1FFC;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input int i);
        case (i)
            0:       return 32'h5555_0000;
            1:       return 32'hAAAA_0001;
            default: return 32'h1234_5678;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input int i);
        case (i)
            0:       return 4'hC;
            1:       return 4'hF;
            default: return 4'h3;
        endcase
    endfunction

    function automatic logic [2:0] onehot(input int w);
        return 3'b001 << w;
    endfunction

    // Expected winner straight from the arbitration rule.
    function automatic int pick_winner(input logic [2:0] p, input int last);
`ifdef STORAGE_ARB_RR_EN
        for (int k = 1; k <= N; k++) begin
            if (p[(last + k) % N]) return (last + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (p[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic add_row(input string name, input logic r, input logic [2:0] rv,
                           input logic [2:0] we, input logic pm, input logic ov,
                           input logic [31:0] dout, input logic [2:0] e_rdy,
                           input logic e_acc, input logic e_wr, input logic [31:0] e_addr,
                           input logic [31:0] e_din, input logic [3:0] e_be,
                           input logic [2:0] e_rsv, input logic [31:0] e_rdata,
                           input logic e_err);
        vec_t v;
        v.name = name;   v.rst = r;       v.rv = rv;       v.we = we;
        v.pm = pm;       v.ov = ov;       v.dout = dout;   v.e_rdy = e_rdy;
        v.e_acc = e_acc; v.e_wr = e_wr;   v.e_addr = e_addr;
        v.e_din = e_din; v.e_be = e_be;   v.e_rsv = e_rsv;
        v.e_rdata = e_rdata; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic idle_row(input string name, input logic r, input logic [2:0] rv,
                            input logic [2:0] we, input logic pm, input logic [2:0] e_rdy);
        add_row(name, r, rv, we, pm, 1'b0, 32'h0BAD_0BAD, e_rdy,
                1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0);
    endtask

    task automatic acc_row(input string name, input logic [2:0] rv, input logic pm,
                           input logic ov, input logic [31:0] dout, input int w,
                           input logic wr);
        add_row(name, 1'b0, rv, 3'b000, pm, ov, dout, 3'b000,
                1'b1, wr, lane_addr(w), lane_wdata(w), lane_be(w), 3'b000, 32'h0, 1'b0);
    endtask

    task automatic resp_row(input string name, input logic [2:0] rv, input logic pm,
                            input int w, input logic [31:0] rdata, input logic err);
        add_row(name, 1'b0, rv, 3'b000, pm, 1'b0, 32'h0BAD_0BAD, 3'b000,
                1'b0, 1'b0, 32'h0, 32'h0, 4'h0, onehot(w), rdata, err);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst       = v.rst;
        req_valid = v.rv;
        req_we    = v.we;
        prog_mode = v.pm;
        out_valid = v.ov;
        d_out     = v.dout;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_row(input vec_t v);
        checkOutput({v.name, ".req_ready"},  32'(req_ready),         32'(v.e_rdy));
        checkOutput({v.name, ".mem_access"}, 32'(memory_access),     32'(v.e_acc));
        checkOutput({v.name, ".mem_write"},  32'(memory_is_writing), 32'(v.e_wr));
        checkOutput({v.name, ".addr"},       addr,                   v.e_addr);
        checkOutput({v.name, ".d_in"},       d_in,                   v.e_din);
        checkOutput({v.name, ".mem_be"},     32'(mem_be),            32'(v.e_be));
        checkOutput({v.name, ".rsp_valid"},  32'(rsp_valid),         32'(v.e_rsv));
        checkOutput({v.name, ".rsp_rdata"},  rsp_rdata,              v.e_rdata);
        checkOutput({v.name, ".rsp_err"},    32'(rsp_err),           32'(v.e_err));
    endtask

    // Random-phase state: pending requests and the outstanding transaction.
    logic [2:0]  pend;
    logic [2:0]  p_we;
    logic [31:0] p_addr [3];
    logic [31:0] p_wd   [3];
    logic [3:0]  p_be   [3];

    initial begin
        int acc_cycles;
        int saw_end;
        int last_w;
        bit active;
        bit resp_due;
        int acc_cnt;
        int delay;
        int t_w;
        logic        t_we;
        logic [31:0] t_addr;
        logic [31:0] t_wd;
        logic [3:0]  t_be;
        logic [31:0] exp_rdata;
        logic        exp_err;

        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        prog_mode = 1'b0;
        out_valid = 1'b0;
        d_out     = '0;
        req_addr  = {lane_addr(2), lane_addr(1), lane_addr(0)};
        req_wdata = {lane_wdata(2), lane_wdata(1), lane_wdata(0)};
        req_be    = {lane_be(2), lane_be(1), lane_be(0)};
        repeat (2) @(posedge clk);

        idle_row("reset", 1'b1, 3'b000, 3'b000, 1'b0, 3'b000);

        idle_row("rd_grant", 1'b0, 3'b010, 3'b000, 1'b0, 3'b010);
        acc_row ("rd_acc1", 3'b000, 1'b0, 1'b0, 32'h0BAD_0BAD, 1, 1'b0);
        acc_row ("rd_acc2", 3'b000, 1'b0, 1'b1, 32'hDEAD_BEEF, 1, 1'b0);
        resp_row("rd_resp", 3'b000, 1'b0, 1, 32'hDEAD_BEEF, 1'b0);
        idle_row("rd_idle", 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);

        idle_row("wr_grant", 1'b0, 3'b100, 3'b100, 1'b0, 3'b100);
        acc_row ("wr_acc", 3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF, 2, 1'b1);
        resp_row("wr_resp", 3'b000, 1'b0, 2, 32'h0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            int w;
`ifdef STORAGE_ARB_RR_EN
            w = k % N;
`else
            w = 0;
`endif
            idle_row($sformatf("ct_grant%0d", k), 1'b0, 3'b111, 3'b000, 1'b0, onehot(w));
            acc_row ($sformatf("ct_acc%0d", k), 3'b111, 1'b0, 1'b1, 32'hC0DE_0000 | 32'(k), w, 1'b0);
            resp_row($sformatf("ct_resp%0d", k), 3'b111, 1'b0, w, 32'hC0DE_0000 | 32'(k), 1'b0);
        end
        idle_row("ct_end", 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);

        for (int k = 0; k < 20; k++) begin
            idle_row($sformatf("pm_block%0d", k), 1'b0, 3'b001, 3'b000, 1'b1, 3'b000);
        end
        idle_row("pm_drop", 1'b0, 3'b001, 3'b000, 1'b0, 3'b001);
        acc_row ("pm_acc1", 3'b000, 1'b1, 1'b0, 32'h0BAD_0BAD, 0, 1'b0);
        acc_row ("pm_acc2", 3'b000, 1'b1, 1'b1, 32'h600D_600D, 0, 1'b0);
        resp_row("pm_resp", 3'b000, 1'b1, 0, 32'h600D_600D, 1'b0);
        idle_row("pm_hold", 1'b0, 3'b001, 3'b000, 1'b1, 3'b000);
        idle_row("pm_end", 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);

        idle_row("rs_grant", 1'b0, 3'b010, 3'b000, 1'b0, 3'b010);
        acc_row ("rs_acc1", 3'b000, 1'b0, 1'b0, 32'h0BAD_0BAD, 1, 1'b0);
        add_row ("rs_acc2", 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 32'h0BAD_0BAD, 3'b000,
                 1'b1, 1'b0, lane_addr(1), lane_wdata(1), lane_be(1), 3'b000, 32'h0, 1'b0);
        idle_row("rs_after", 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);
        idle_row("rs_regrant", 1'b0, 3'b111, 3'b000, 1'b0, 3'b001);
        acc_row ("rs_acc", 3'b000, 1'b0, 1'b1, 32'h0000_0077, 0, 1'b0);
        resp_row("rs_resp", 3'b000, 1'b0, 0, 32'h0000_0077, 1'b0);
        idle_row("rs_idle", 1'b0, 3'b000, 3'b000, 1'b0, 3'b000);

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            check_row(vecs[i]);
        end

        // Timeout: the controller never answers, so the access must last
        // exactly TMO cycles and complete with an error in cycle TMO+1.
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 3'b010;
        req_we    = 3'b000;
        prog_mode = 1'b0;
        out_valid = 1'b0;
        d_out     = 32'hFEED_FACE;
        #1;
        checkOutput("tmo.grant", 32'(req_ready), 32'(3'b010));
        acc_cycles = 0;
        saw_end    = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            req_valid = 3'b000;
            d_out     = $urandom;
            #1;
            if (memory_access) begin
                acc_cycles++;
            end else begin
                saw_end = 1;
                break;
            end
        end
        checkOutput("tmo.access_cycles", 32'(acc_cycles), 32'(TMO));
        checkOutput("tmo.ended", 32'(saw_end), 32'd1);
        checkOutput("tmo.rsp_valid", 32'(rsp_valid), 32'(3'b010));
        checkOutput("tmo.rsp_err", 32'(rsp_err), 32'd1);
        checkOutput("tmo.rsp_rdata", rsp_rdata, 32'h0);

        // Randomized traffic against the transaction-level model.
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        prog_mode = 1'b0;
        out_valid = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        pend     = '0;
        p_we     = '0;
        last_w   = N - 1;
        active   = 0;
        resp_due = 0;
        acc_cnt  = 0;
        delay    = 0;
        t_w = 0; t_we = 0; t_addr = '0; t_wd = '0; t_be = '0;
        exp_rdata = '0; exp_err = 0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
                    pend[i]   = 1'b1;
                    p_we[i]   = 1'($urandom_range(0, 1));
                    p_addr[i] = $urandom;
                    p_wd[i]   = $urandom;
                    p_be[i]   = 4'($urandom_range(0, 15));
                end
            end
            req_valid = pend;
            req_we    = p_we;
            for (int i = 0; i < N; i++) begin
                req_addr[32*i +: 32]  = p_addr[i];
                req_wdata[32*i +: 32] = p_wd[i];
                req_be[4*i +: 4]      = p_be[i];
            end
            prog_mode = ($urandom_range(0, 7) == 0);
            d_out     = $urandom;
            out_valid = active && (acc_cnt == delay);
            #1;
            if (resp_due) begin
                checkOutput("rnd.rsp_valid", 32'(rsp_valid), 32'(onehot(t_w)));
                checkOutput("rnd.rsp_rdata", rsp_rdata, exp_rdata);
                checkOutput("rnd.rsp_err", 32'(rsp_err), 32'(exp_err));
                checkOutput("rnd.resp_access", 32'(memory_access), 32'd0);
                checkOutput("rnd.resp_ready", 32'(req_ready), 32'd0);
                resp_due = 0;
            end else if (active) begin
                checkOutput("rnd.access", 32'(memory_access), 32'd1);
                checkOutput("rnd.write", 32'(memory_is_writing), 32'(t_we));
                checkOutput("rnd.addr", addr, t_addr);
                checkOutput("rnd.d_in", d_in, t_wd);
                checkOutput("rnd.mem_be", 32'(mem_be), 32'(t_be));
                checkOutput("rnd.acc_ready", 32'(req_ready), 32'd0);
                checkOutput("rnd.acc_rsp", 32'(rsp_valid), 32'd0);
                if (out_valid) begin
                    exp_rdata = t_we ? 32'h0 : d_out;
                    exp_err   = 1'b0;
                    resp_due  = 1;
                    active    = 0;
                end else if (acc_cnt == TMO - 1) begin
                    exp_rdata = 32'h0;
                    exp_err   = 1'b1;
                    resp_due  = 1;
                    active    = 0;
                end else begin
                    acc_cnt++;
                end
            end else begin
                int w;
                w = (!prog_mode && (pend != 0)) ? pick_winner(pend, last_w) : -1;
                checkOutput("rnd.idle_access", 32'(memory_access), 32'd0);
                checkOutput("rnd.idle_addr", addr, 32'h0);
                checkOutput("rnd.idle_rsp", 32'(rsp_valid), 32'd0);
                checkOutput("rnd.grant", 32'(req_ready), (w >= 0) ? 32'(onehot(w)) : 32'd0);
                if (w >= 0) begin
                    t_w     = w;
                    t_we    = p_we[w];
                    t_addr  = p_addr[w];
                    t_wd    = p_wd[w];
                    t_be    = p_be[w];
                    last_w  = w;
                    pend[w] = 1'b0;
                    active  = 1;
                    acc_cnt = 0;
                    delay   = $urandom_range(0, TMO + 1);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
